// File: rtl/board_writer.sv
// rtl/board_writer.sv - Score 4 board register with animated column drops
// Pieces fall one row per FALL_CYCLES clocks, then land and pass the turn.
module board_writer #(
  parameter int FALL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_game,
  input  logic                  move_valid,
  input  logic [2:0]            move_col,
  output logic [6:0][5:0][1:0]  panel,
  output logic [1:0]            turn,
  output logic                  busy,
  output logic                  illegal,
  output logic                  done,
  output logic [2:0]            last_col,
  output logic [2:0]            last_row
);

  localparam logic [7:0] CNT_MAX = 8'(FALL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FALL, LAND} state_t;

  state_t                 state, state_d;
  logic [2:0]             col, col_d;
  logic [2:0]             row, row_d;
  logic [2:0]             row_inc;
  logic [7:0]             cnt, cnt_d;
  logic [6:0][5:0][1:0]   panel_d;
  logic [1:0]             turn_d;
  logic                   busy_d, illegal_d, done_d;
  logic [2:0]             last_col_d, last_row_d;

  assign row_inc = row + 3'd1;

  always_comb begin
    state_d    = state;
    col_d      = col;
    row_d      = row;
    cnt_d      = cnt;
    panel_d    = panel;
    turn_d     = turn;
    busy_d     = busy;
    illegal_d  = 1'b0;
    done_d     = 1'b0;
    last_col_d = last_col;
    last_row_d = last_row;
    if (new_game) begin
      state_d    = IDLE;
      col_d      = 3'd0;
      row_d      = 3'd0;
      cnt_d      = 8'd0;
      panel_d    = '0;
      turn_d     = 2'b01;
      busy_d     = 1'b0;
      last_col_d = 3'd0;
      last_row_d = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (move_valid) begin
            // Short-circuit keeps the out-of-range column from indexing the board.
            if (move_col > 3'd6 || panel[move_col][0] != 2'b00) begin
              illegal_d = 1'b1;
            end else begin
              col_d                = move_col;
              panel_d[move_col][0] = turn;
              row_d                = 3'd0;
              cnt_d                = 8'd0;
              busy_d               = 1'b1;
              state_d              = FALL;
            end
          end
        end
        FALL: begin
          if (cnt == CNT_MAX) begin
            cnt_d = 8'd0;
            if (row == 3'd5 || panel[col][row_inc] != 2'b00) begin
              state_d = LAND;
            end else begin
              // Clear and set in the same update so the piece is never doubled.
              panel_d[col][row]     = 2'b00;
              panel_d[col][row_inc] = turn;
              row_d                 = row_inc;
            end
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
        LAND: begin
          last_col_d = col;
          last_row_d = row;
          done_d     = 1'b1;
          turn_d     = {turn[0], turn[1]};
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col      <= 3'd0;
      row      <= 3'd0;
      cnt      <= 8'd0;
      panel    <= '0;
      turn     <= 2'b01;
      busy     <= 1'b0;
      illegal  <= 1'b0;
      done     <= 1'b0;
      last_col <= 3'd0;
      last_row <= 3'd0;
    end else begin
      state    <= state_d;
      col      <= col_d;
      row      <= row_d;
      cnt      <= cnt_d;
      panel    <= panel_d;
      turn     <= turn_d;
      busy     <= busy_d;
      illegal  <= illegal_d;
      done     <= done_d;
      last_col <= last_col_d;
      last_row <= last_row_d;
    end
  end

endmodule

// File: doc/board_writer.md
Name: board_writer

Overview:
- Write side of the Score 4 board. It owns the 7-column x 6-row board register and takes column-drop requests for the current player.
- Each piece falls one row at a time, so the display can animate it. The piece lands on the first occupied cell or the bottom row, then the turn passes to the other player.
- The board output feeds the display, the full-board detector and the win checker.

Parameters:
- FALL_CYCLES, 4, clock cycles per one-row fall step; legal range 1..255.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- new_game  input  1  synchronous board clear and game restart.
- move_valid  input  1  drop request strobe.
- move_col  input  3  requested column, 0..6.
- panel  output  [6:0][5:0][1:0]  board as [column][row][cell]. Row 0 is the top row and row 5 is the bottom row. Cell codes: 00 empty, 01 player 1, 10 player 2; 11 is never written.
- turn  output  2  cell code of the player to move, 01 or 10.
- busy  output  1  high while a piece is falling or landing.
- illegal  output  1  one-cycle pulse when a request is rejected.
- done  output  1  one-cycle pulse when a piece has landed.
- last_col  output  3  column of the most recently landed piece.
- last_row  output  3  row of the most recently landed piece.

Behaviour:
- Reset (rst=1 at a clk edge):
  - panel all 00, turn=01, busy=0, illegal=0, done=0, last_col=0, last_row=0.
  - State IDLE; fall counter cleared.
- new_game=1 has the same effect as reset, with priority below rst and above everything else.
  - It takes effect in any state; a piece mid-fall is removed and the move is abandoned.
- Registers: all outputs are registered. illegal and done are high for exactly one cycle.
- IDLE state, on move_valid=1:
  - Rejected if move_col>6 or panel[move_col][0]!=00. Then illegal=1 on the next cycle, panel and turn are unchanged, and the state stays IDLE.
  - Otherwise: latch the column, write turn into panel[col][0], set row=0, clear the counter, busy=1, go to FALL. The change is visible on the next cycle.
- FALL state:
  - The counter increments each cycle.
  - When the counter reaches FALL_CYCLES-1, it is cleared and one step is evaluated:
    - If row==5 or panel[col][row+1]!=00, go to LAND.
    - Otherwise write 00 to panel[col][row] and turn to panel[col][row+1], then row=row+1. This is a single-cycle update, so the piece is never duplicated or missing.
  - move_valid is ignored while in FALL or LAND: no illegal pulse and no queuing.
- LAND state (one cycle):
  - Register last_col=col, last_row=row, done=1.
  - Toggle turn (01<->10) and set busy=0, all visible on the same cycle as done.
  - Return to IDLE.
  - A move_valid on the done cycle is accepted normally.
- Latency, request to done, for a drop through k empty rows below the entry row (k=0..5): 1 + (k+1)*FALL_CYCLES + 1 cycles.
- Boundary cases:
  - A column whose top cell is occupied is full. Any request to it is illegal.
  - A full board is not detected here. Every request to a full board is rejected as illegal.
  - A piece entering at row 0 of a column holding 5 pieces lands immediately at row 0 after one step interval.
  - Row indices never exceed 5 and the column index never exceeds 6, so no wrap-around occurs.

Test Plan:
- Reset, then move_col=3, FALL_CYCLES=4 -> piece visits rows 0..5 of column 3, one row per 4 cycles. done arrives 26 cycles after the request; panel[3][5]=01, last_row=5, turn=10, only one nonzero cell on every cycle.
- Stack column 0 six times with alternating players -> bottom-to-top codes 01,10,01,10,01,10 and last_row values 5,4,3,2,1,0. A seventh request gives illegal=1 and panel and turn are unchanged.
- Request move_col=7 in IDLE -> one-cycle illegal pulse; busy stays 0 and turn is unchanged.
- move_valid pulses during FALL to another column -> ignored; no illegal pulse and only the original column changes.
- Assert new_game when the piece is at row 2 of column 5 -> next cycle panel is all 00, turn=01, busy=0, and no done pulse follows.
- Fill all 42 cells by round-robin columns -> final board has 21 cells of 01 and 21 of 10, and every further request is illegal. Also hold move_valid high on the done cycle: the next move starts immediately.
